dmem_store_buffer: RTL and testbench
====================================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 The block SHALL have exactly one parameter: DEPTH, default 4, number of store-buffer entries; only the value 4 is supported, so pointers are 2 bits and the count runs 0..4.
REQ-002 The block SHALL have the following ports, one per line: name direction width meaning.
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- cpu_memwrite  input  1  MEM-stage store request
- cpu_memread  input  1  MEM-stage load request
- cpu_addr  input  32  byte address; bits [31:2] are used for word matching
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data returned to the MEM/WB register
- stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM when high
- mem_req  output  1  memory request; held high until it is acknowledged
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_ack  input  1  memory acknowledge; single-cycle pulse
- mem_rdata  input  32  read data; valid in the cycle mem_ack is high
- empty  output  1  high when the buffer holds no stores

Function
REQ-003 Storage SHALL be a circular FIFO of DEPTH entries, each holding {addr[31:2], data}, with 2-bit head and tail pointers that wrap from 3 to 0 and a 3-bit count.
REQ-004 The FSM SHALL have three states, IDLE, WRITE and READ, with transitions evaluated on the rising edge of clk.
REQ-005 IDLE->READ: taken when a load miss is pending. This transition has priority over draining.
REQ-006 IDLE->WRITE: taken when count>0 and no load miss is pending.
REQ-007 On entry to WRITE, mem_addr SHALL be {head addr, 2'b00} and mem_wdata SHALL be the head data.
REQ-008 On entry to READ, mem_addr SHALL be {cpu_addr[31:2], 2'b00}.
REQ-009 Both mem_addr and mem_wdata SHALL be registered at state entry.
REQ-010 WRITE->IDLE and READ->IDLE SHALL occur on the edge at which mem_ack=1.
REQ-011 A WRITE ack SHALL pop the head entry on that same edge.
REQ-012 mem_req SHALL equal (state != IDLE), and mem_we SHALL equal (state == WRITE).
REQ-013 Only one memory transaction SHALL be outstanding at a time, and mem_ack SHALL be ignored while the state is IDLE.
REQ-014 Store acceptance: when cpu_memwrite=1 and count<4, the entry SHALL be enqueued at the tail on the next edge and stall SHALL be 0.
REQ-015 Store with a full buffer: when count==4, stall SHALL be 1 and no enqueue SHALL occur; fullness is taken from the registered count, so a same-cycle pop does not release the stall.
REQ-016 Simultaneous enqueue and pop SHALL leave count unchanged, with both pointers advancing.
REQ-017 Load hit: when cpu_memread=1 and any valid entry's addr matches cpu_addr[31:2], cpu_rdata SHALL be the data of the youngest matching entry, combinationally, with stall=0.
REQ-018 Load miss: when cpu_memread=1 and no entry matches, stall SHALL be 1, except in a cycle where state==READ and mem_ack=1; in that cycle stall=0 and cpu_rdata=mem_rdata.
REQ-019 A load miss arriving while in WRITE SHALL wait for that write's ack, then enter READ on the following edge.
REQ-020 Stores to an already-buffered address SHALL be enqueued as new entries and never merged.
REQ-021 cpu_memwrite and cpu_memread both high SHALL be treated as a store only.
REQ-022 When no load is active, cpu_rdata SHALL be 32'b0.
REQ-023 empty SHALL equal (count==0).
REQ-024 Latency: a store into an empty idle buffer accepted at edge T SHALL produce mem_req=1 after edge T+1.
REQ-025 Latency: a load miss first presented in cycle C SHALL produce mem_req=1 in cycle C+1; the minimum stall is 1 cycle, reached when mem_ack arrives in C+1.

Reset
REQ-026 While reset=1 at a rising edge, the next state SHALL be count=0, head=0, tail=0, state=IDLE, with mem_addr and mem_wdata cleared to 0.
REQ-027 While reset=1, stall SHALL be forced to 0.
REQ-028 Outputs SHALL reset to mem_req=0, mem_we=0, empty=1, stall=0 and cpu_rdata=0.
REQ-029 Reset during WRITE or READ SHALL abandon the transaction and discard buffered stores; a late mem_ack arriving after reset SHALL be ignored.

Verification
REQ-030 Single store: write 0x100<=0xDEADBEEF into an empty buffer, with memory acking 2 cycles after req. Required: stall=0 throughout; one write with mem_addr=0x100 and mem_wdata=0xDEADBEEF; empty returns to 1.
REQ-031 Full buffer: issue 5 back-to-back stores with memory ack held low. Required: stall=1 on the 5th store; after the first ack, the 5th store is accepted the cycle after stall drops; memory sees the writes in program order.
REQ-032 Forwarding: buffer 0x200<=1, then 0x200<=2, then load 0x202. Required: cpu_rdata=2 in the same cycle, stall=0, and no mem read is issued.
REQ-033 Load bypass: with 2 stores pending to 0x300 and 0x304 and the state IDLE, load 0x400 with memory returning 0x55 with immediate ack. Required: the read is issued before any write; stall is high for 1 cycle; cpu_rdata=0x55 in the ack cycle.
REQ-034 Load during write: a load miss arrives while a write is in flight. Required: no read is issued until the write's ack; READ starts on the next edge.
REQ-035 Reset mid-WRITE with 3 stores buffered. Required: mem_req=0 and empty=1 after the reset edge; a mem_ack pulse one cycle later causes no pop or state change.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// dmem_store_buffer
//
// Data-memory store buffer that sits between the MEM stage of a pipelined CPU
// and a single-port memory. Stores go into a small FIFO and the CPU does not
// wait for them. The FIFO drains to memory in the background. Loads take data
// from the youngest matching buffered store when one exists. Otherwise the CPU
// stalls while a memory read is issued. A load miss takes priority over
// draining, so a read can overtake older buffered writes. This is safe because
// no entry matches the load address.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   cpu_memwrite          MEM-stage store request (wins if cpu_memread is also set)
//   cpu_memread           MEM-stage load request
//   cpu_addr, cpu_wdata   byte address (word matched on [31:2]) and store data
//   cpu_rdata             load data; 0 when no load is active
//   stall                 freezes the front of the pipeline
//   mem_req, mem_we       memory request (held until ack) and write enable
//   mem_addr, mem_wdata   registered memory address / write data
//   mem_ack, mem_rdata    single-cycle acknowledge and read data
//   empty                 buffer holds no stores
//
// Handshake: mem_req is high for the whole life of one transaction. The
// transaction completes on the rising edge at which mem_ack is high. mem_ack is
// ignored when no transaction is outstanding.
// -----------------------------------------------------------------------------
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // FIFO storage. The contents are not reset. Validity comes only from
    // head/count, so clearing the pointers discards every entry.
    logic [29:0] buf_addr_q [DEPTH];
    logic [31:0] buf_data_q [DEPTH];

    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    state_t      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        load_active;
    logic        hit;
    logic [31:0] hit_data;
    logic        load_miss;
    logic        read_done;
    logic        full;
    logic        enq;
    logic        pop;

    // Byte-offset bits do not take part in word matching.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // A simultaneous store and load is a store only.
    assign load_active = cpu_memread & ~cpu_memwrite;

    // Scan from oldest (head) to youngest. A later match overrides an earlier
    // one, so the youngest matching store supplies the data.
    always_comb begin
        hit      = 1'b0;
        hit_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((3'(i) < count_q) &&
                (buf_addr_q[head_q + 2'(i)] == cpu_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = buf_data_q[head_q + 2'(i)];
            end
        end
    end

    assign load_miss = load_active & ~hit;
    assign read_done = (state_q == READ) & mem_ack;
    // Fullness uses the registered count. A pop in the same cycle does not
    // free a slot until the next cycle.
    assign full      = (count_q == 3'd4);
    assign enq       = cpu_memwrite & ~full;
    assign pop       = (state_q == WRITE) & mem_ack;

    // The miss stall drops in the cycle the read data arrives, so the load
    // completes in that cycle with mem_rdata passed straight through.
    assign stall = ~reset & ((cpu_memwrite & full) | (load_miss & ~read_done));

    always_comb begin
        cpu_rdata = 32'd0;
        if (load_active) begin
            if (hit) begin
                cpu_rdata = hit_data;
            end else if (read_done) begin
                cpu_rdata = mem_rdata;
            end
        end
    end

    // Pointer and count bookkeeping. A push and a pop in the same cycle leave
    // the count unchanged.
    always_comb begin
        head_d  = head_q + {1'b0, pop};
        tail_d  = tail_q + {1'b0, enq};
        count_d = count_q + {2'b00, enq} - {2'b00, pop};
    end

    // Next-state logic. The memory address and write data are captured when the
    // FSM enters a state, so they stay stable while mem_req is held.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d    = READ;
                    mem_addr_d = {cpu_addr[31:2], 2'b00};
                end else if (count_q != 3'd0) begin
                    state_d     = WRITE;
                    mem_addr_d  = {buf_addr_q[head_q], 2'b00};
                    mem_wdata_d = buf_data_q[head_q];
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= 2'd0;
            tail_q      <= 2'd0;
            count_q     <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            buf_addr_q[tail_q] <= cpu_addr[31:2];
            buf_data_q[tail_q] <= cpu_wdata;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign empty     = (count_q == 3'd0);

endmodule

// File: tb/tb_dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dmem_store_buffer
//
// Directed bench for dmem_store_buffer. Inputs change 1 time unit after the
// rising edge. Outputs are sampled on the falling edge. Each accepted store
// pushes its expected {word address, data} onto exp_q. A monitor pops exp_q on
// every acknowledged memory write, so writes are checked in program order.
// -----------------------------------------------------------------------------
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        empty;

    int          n_checks = 0;
    int          n_errors = 0;
    int          writes_done = 0;
    int          reads_done = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    dmem_store_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .empty        (empty)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // A store that the bench knows will be accepted: no stall, and it enters
    // the scoreboard.
    task automatic store_ok(input logic [31:0] a, input logic [31:0] d);
        cpu_memwrite = 1'b1;
        cpu_memread  = 1'b0;
        cpu_addr     = a;
        cpu_wdata    = d;
        sample();
        check("store_stall", {31'd0, stall}, 32'd0);
        exp_q.push_back({a & 32'hFFFF_FFFC, d});
        next_cycle();
    endtask

    // Memory model that acks every write immediately until the buffer is empty
    // and idle.
    task automatic drain(input string tag);
        int budget = 100;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
        while (!(empty && !mem_req) && budget > 0) begin
            mem_ack = mem_req & mem_we;
            next_cycle();
            budget--;
        end
        mem_ack = 1'b0;
        n_checks++;
        assert (budget > 0) else begin
            n_errors++;
            $error("FAIL %s_timeout: observed=budget expired expected=drained", tag);
        end
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && mem_req && mem_ack) begin
            if (mem_we) begin
                writes_done++;
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL wr_unexpected: observed addr=%h expected=no write", mem_addr);
                end
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, exp_e[63:32]);
                    check("wr_data", mem_wdata, exp_e[31:0]);
                end
            end else begin
                reads_done++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int r_before;
        int w_before;

        // Reset, with a load miss presented to show the stall is forced low.
        reset        = 1'b1;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b1;
        cpu_addr     = 32'h0000_0900;
        cpu_wdata    = 32'd0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'd0;
        next_cycle();
        next_cycle();
        sample();
        check("rst_stall_forced", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_rdata", cpu_rdata, 32'd0);
        next_cycle();
        reset       = 1'b0;
        cpu_memread = 1'b0;
        sample();
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        next_cycle();

        // Single store, memory acks two cycles after the request.
        store_ok(32'h0000_0100, 32'hDEAD_BEEF);
        cpu_memwrite = 1'b0;
        sample();
        check("t1_req_after_T", {31'd0, mem_req}, 32'd0);
        check("t1_not_empty", {31'd0, empty}, 32'd0);
        next_cycle();
        sample();
        check("t1_req", {31'd0, mem_req}, 32'd1);
        check("t1_we", {31'd0, mem_we}, 32'd1);
        check("t1_addr", mem_addr, 32'h0000_0100);
        check("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        sample();
        check("t1_req_held", {31'd0, mem_req}, 32'd1);
        check("t1_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        check("t1_stall_ack", {31'd0, stall}, 32'd0);
        next_cycle();
        mem_ack = 1'b0;
        sample();
        check("t1_req_done", {31'd0, mem_req}, 32'd0);
        check("t1_empty_again", {31'd0, empty}, 32'd1);
        next_cycle();

        // Full buffer: five back-to-back stores, ack held low.
        for (int i = 0; i < 4; i++) begin
            store_ok(32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        cpu_memwrite = 1'b1;
        cpu_addr     = 32'h20;
        cpu_wdata    = 32'hA4;
        sample();
        check("t2_full_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        check("t2_ack_cycle_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        mem_ack = 1'b0;
        sample();
        check("t2_stall_released", {31'd0, stall}, 32'd0);
        exp_q.push_back({32'h20, 32'hA4});
        next_cycle();
        drain("t2");

        // Forwarding from the youngest of two stores to the same word.
        r_before = reads_done;
        store_ok(32'h0000_0200, 32'd1);
        cpu_memwrite = 1'b1;
        cpu_memread  = 1'b1;
        cpu_addr     = 32'h0000_0200;
        cpu_wdata    = 32'd2;
        sample();
        check("t3_wr_rd_is_store_rdata", cpu_rdata, 32'd0);
        check("t3_wr_rd_stall", {31'd0, stall}, 32'd0);
        exp_q.push_back({32'h0000_0200, 32'd2});
        next_cycle();
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b1;
        cpu_addr     = 32'h0000_0202;
        sample();
        check("t3_fwd_rdata", cpu_rdata, 32'd2);
        check("t3_fwd_stall", {31'd0, stall}, 32'd0);
        check("t3_fwd_still_write", {31'd0, mem_we}, 32'd1);
        next_cycle();
        cpu_memread = 1'b0;
        sample();
        check("t3_no_load_rdata", cpu_rdata, 32'd0);
        next_cycle();
        drain("t3");
        check("t3_no_read", 32'(reads_done), 32'(r_before));

        // Load bypass: two stores pending with the FSM idle. The pop and push in
        // the same cycle must keep both entries.
        store_ok(32'h0000_00F0, 32'h11);
        store_ok(32'h0000_0300, 32'h22);
        cpu_memwrite = 1'b1;
        cpu_addr     = 32'h0000_0304;
        cpu_wdata    = 32'h33;
        mem_ack      = 1'b1;
        sample();
        check("t4_push_pop_stall", {31'd0, stall}, 32'd0);
        check("t4_push_pop_we", {31'd0, mem_we}, 32'd1);
        exp_q.push_back({32'h0000_0304, 32'h33});
        next_cycle();
        cpu_memwrite = 1'b0;
        mem_ack      = 1'b0;
        cpu_memread  = 1'b1;
        cpu_addr     = 32'h0000_0400;
        r_before     = reads_done;
        w_before     = writes_done;
        sample();
        check("t4_miss_stall", {31'd0, stall}, 32'd1);
        check("t4_miss_req", {31'd0, mem_req}, 32'd0);
        check("t4_two_pending", {31'd0, empty}, 32'd0);
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'h55;
        sample();
        check("t4_read_req", {31'd0, mem_req}, 32'd1);
        check("t4_read_we", {31'd0, mem_we}, 32'd0);
        check("t4_read_addr", mem_addr, 32'h0000_0400);
        check("t4_ack_stall", {31'd0, stall}, 32'd0);
        check("t4_ack_rdata", cpu_rdata, 32'h55);
        check("t4_read_before_write", 32'(writes_done), 32'(w_before));
        next_cycle();
        check("t4_read_count", 32'(reads_done), 32'(r_before + 1));
        cpu_memread = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        sample();
        check("t4_idle_rdata", cpu_rdata, 32'd0);
        next_cycle();
        drain("t4");

        // A load miss arriving while a write is in flight.
        store_ok(32'h0000_0500, 32'd7);
        cpu_memwrite = 1'b0;
        sample();
        next_cycle();
        cpu_memread = 1'b1;
        cpu_addr    = 32'h0000_0600;
        sample();
        check("t5_wait_stall", {31'd0, stall}, 32'd1);
        check("t5_wait_we", {31'd0, mem_we}, 32'd1);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        check("t5_wr_ack_stall", {31'd0, stall}, 32'd1);
        check("t5_wr_ack_we", {31'd0, mem_we}, 32'd1);
        next_cycle();
        mem_ack = 1'b0;
        sample();
        check("t5_gap_req", {31'd0, mem_req}, 32'd0);
        check("t5_gap_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_1234;
        sample();
        check("t5_read_we", {31'd0, mem_we}, 32'd0);
        check("t5_read_addr", mem_addr, 32'h0000_0600);
        check("t5_read_stall", {31'd0, stall}, 32'd0);
        check("t5_read_rdata", cpu_rdata, 32'h0000_1234);
        next_cycle();
        cpu_memread = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        sample();
        check("t5_done_req", {31'd0, mem_req}, 32'd0);
        check("t5_done_empty", {31'd0, empty}, 32'd1);
        check("t5_queue_left", 32'(exp_q.size()), 32'd0);
        next_cycle();

        // Reset in the middle of a write with three stores buffered.
        store_ok(32'h0000_0700, 32'h70);
        store_ok(32'h0000_0704, 32'h71);
        store_ok(32'h0000_0708, 32'h72);
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b1;
        cpu_addr     = 32'h0000_0900;
        reset        = 1'b1;
        sample();
        check("t6_rst_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        exp_q.delete();
        reset       = 1'b0;
        cpu_memread = 1'b0;
        sample();
        check("t6_req_after_rst", {31'd0, mem_req}, 32'd0);
        check("t6_empty_after_rst", {31'd0, empty}, 32'd1);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        check("t6_late_ack_req", {31'd0, mem_req}, 32'd0);
        check("t6_late_ack_empty", {31'd0, empty}, 32'd1);
        next_cycle();
        mem_ack = 1'b0;
        sample();
        check("t6_after_ack_req", {31'd0, mem_req}, 32'd0);
        check("t6_after_ack_empty", {31'd0, empty}, 32'd1);
        check("t6_addr_cleared", mem_addr, 32'd0);
        next_cycle();
        store_ok(32'h0000_0800, 32'hCAFE_F00D);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
